data_memory_responder: RTL

//  Responder side of the pipeline's load/store interface: owns the data memory array and services one

---
 rtl/data_memory_responder.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/data_memory_responder.sv
// -----------------------------------------------------------------------------
// data_memory_responder
//
// Responder side of the load/store interface. Owns the data memory array and
// services one request at a time over a valid/ready handshake with a fixed
// latency. Supports byte/half/word/double loads (signed or unsigned) and
// stores. Flags misaligned or out-of-range accesses. Drives mem_busy so the
// pipeline holds while an access is outstanding.
//
// Optional feature macro: DMEM_PERF_CNT_EN
//   defined   : saturating counters of good loads, good stores and errors
//   undefined : perf_* ports tied to 32'd0
//
// Parameters
//   DEPTH    number of 64-bit doublewords (index = addr[63:3])
//   LATENCY  cycles from request accept to resp_valid (1..15)
//
// Ports
//   clock, reset        rising-edge clock; synchronous active-high reset
//   req_valid/ready     request handshake (ready only in IDLE)
//   req_write           1 = store, 0 = load
//   req_size            0 byte, 1 half, 2 word, 3 double
//   req_unsigned        loads: zero-extend when set, else sign-extend
//   req_addr            byte address
//   req_wdata           right-justified store data
//   resp_valid          one-cycle response pulse
//   resp_rdata          extended load data; 0 for stores and errors
//   resp_err            misaligned or out-of-range access
//   mem_busy            access outstanding (stall to hazard unit)
//   perf_loads/stores/errors  completed-response counters
// -----------------------------------------------------------------------------
module data_memory_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_busy,
  output logic [31:0] perf_loads,
  output logic [31:0] perf_stores,
  output logic [31:0] perf_errors
);

  localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LOAD_CNT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_r;
  logic [3:0]  count_r;
  logic        write_r;
  logic [1:0]  size_r;
  logic        unsigned_r;
  logic [63:0] addr_r;
  logic [63:0] wdata_r;
  logic        resp_valid_r;
  logic [63:0] resp_rdata_r;
  logic        resp_err_r;

  logic [63:0] mem_r [0:DEPTH-1];

  logic             accept_s;
  logic             access_err_s;
  logic [IDX_W-1:0] index_s;

  // Misalignment for the access size, or doubleword index beyond the array.
  function automatic logic access_error(input logic [63:0] addr, input logic [1:0] size);
    logic misaligned;
    logic out_of_range;
    misaligned   = (addr[0] && (size >= 2'd1)) ||
                   ((addr[1:0] != 2'd0) && (size >= 2'd2)) ||
                   ((addr[2:0] != 3'd0) && (size == 2'd3));
    out_of_range = (addr[63:3] >= 61'(DEPTH));
    return misaligned || out_of_range;
  endfunction

  // Pick size bytes at the lane offset and extend them to 64 bits.
  function automatic logic [63:0] load_extract(input logic [63:0] dword, input logic [2:0] offset,
                                               input logic [1:0] size, input logic is_unsigned);
    logic [63:0] shifted;
    logic [63:0] result;
    shifted = dword >> {offset, 3'b000};
    case (size)
      2'd0:    result = is_unsigned ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      2'd1:    result = is_unsigned ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'd2:    result = is_unsigned ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: result = shifted;
    endcase
    return result;
  endfunction

  // Replace only the addressed byte lanes of the old doubleword.
  function automatic logic [63:0] store_merge(input logic [63:0] old_dword, input logic [63:0] wdata,
                                              input logic [2:0] offset, input logic [1:0] size);
    logic [7:0]  lanes;
    logic [63:0] shifted;
    logic [63:0] result;
    case (size)
      2'd0:    lanes = 8'h01;
      2'd1:    lanes = 8'h03;
      2'd2:    lanes = 8'h0F;
      default: lanes = 8'hFF;
    endcase
    lanes   = lanes << offset;
    shifted = wdata << {offset, 3'b000};
    for (int i = 0; i < 8; i++) begin
      result[8*i +: 8] = lanes[i] ? shifted[8*i +: 8] : old_dword[8*i +: 8];
    end
    return result;
  endfunction

  assign accept_s     = req_valid && (state_r == ST_IDLE);
  assign access_err_s = access_error(addr_r, size_r);
  assign index_s      = addr_r[IDX_W+2:3];

  // Handshake flags decode straight from the state register.
  assign req_ready  = (state_r == ST_IDLE);
  assign mem_busy   = (state_r != ST_IDLE);
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;

  // Request FSM: latch on accept, count down the latency, register the response.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      count_r      <= 4'd0;
      write_r      <= 1'b0;
      size_r       <= 2'd0;
      unsigned_r   <= 1'b0;
      addr_r       <= 64'd0;
      wdata_r      <= 64'd0;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 64'd0;
      resp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          resp_valid_r <= 1'b0;
          if (accept_s) begin
            write_r    <= req_write;
            size_r     <= req_size;
            unsigned_r <= req_unsigned;
            addr_r     <= req_addr;
            wdata_r    <= req_wdata;
            count_r    <= LOAD_CNT;
            state_r    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (count_r == 4'd0) begin
            // Response is prepared here so it is registered for the RESP cycle.
            state_r      <= ST_RESP;
            resp_valid_r <= 1'b1;
            resp_err_r   <= access_err_s;
            resp_rdata_r <= (access_err_s || write_r) ? 64'd0 :
                            load_extract(mem_r[index_s], addr_r[2:0], size_r, unsigned_r);
          end else begin
            count_r <= count_r - 4'd1;
          end
        end
        ST_RESP: begin
          state_r      <= ST_IDLE;
          resp_valid_r <= 1'b0;
          resp_rdata_r <= 64'd0;
          resp_err_r   <= 1'b0;
        end
        default: begin
          state_r      <= ST_IDLE;
          count_r      <= 4'd0;
          resp_valid_r <= 1'b0;
          resp_rdata_r <= 64'd0;
          resp_err_r   <= 1'b0;
        end
      endcase
    end
  end

  // Array write: read-modify-write of the doubleword on the edge that ends RESP.
  always_ff @(posedge clock) begin
    if (!reset && (state_r == ST_RESP) && write_r && !access_err_s) begin
      mem_r[index_s] <= store_merge(mem_r[index_s], wdata_r, addr_r[2:0], size_r);
    end
  end

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] perf_loads_r;
  logic [31:0] perf_stores_r;
  logic [31:0] perf_errors_r;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : (value + 32'd1);
  endfunction

  // Performance counters bump once per response, by response class.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_loads_r  <= 32'd0;
      perf_stores_r <= 32'd0;
      perf_errors_r <= 32'd0;
    end else if (state_r == ST_RESP) begin
      if (access_err_s) begin
        perf_errors_r <= sat_inc(perf_errors_r);
      end else if (write_r) begin
        perf_stores_r <= sat_inc(perf_stores_r);
      end else begin
        perf_loads_r  <= sat_inc(perf_loads_r);
      end
    end
  end

  assign perf_loads  = perf_loads_r;
  assign perf_stores = perf_stores_r;
  assign perf_errors = perf_errors_r;
`else
  assign perf_loads  = 32'd0;
  assign perf_stores = 32'd0;
  assign perf_errors = 32'd0;
`endif

endmodule
